// File: rtl/vdp_super_vram_prefetch.sv
// Line-prefetch FIFO feeding the super-res renderer from VRAM during the super-res bus window.
// Optional underrun statistics counter enabled by defining VDP_SUPER_PREFETCH_STATS_EN.
module vdp_super_vram_prefetch #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vdp_super,
    input  logic        super_res_drawing,
    input  logic        line_start,
    input  logic [17:0] line_addr,
    input  logic [8:0]  line_words,
    input  logic        word_pop,
    output logic [31:0] vrm_32,
    output logic        word_valid,
    output logic        mem_rd_req,
    output logic [17:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t         state_reg, state_next;
    logic           drop_reg, drop_next;
    logic [17:0]    mem_addr_reg;
    logic [17:0]    next_addr_reg;
    logic [8:0]     words_left_reg;
    logic [CW-1:0]  count_reg;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]  rd_ptr_inc;
    logic [31:0]    vrm_reg;
    logic           underrun_reg;
    logic [31:0]    mem_reg [DEPTH];

    logic           flush;
    logic           can_issue;
    logic           issue;
    logic           push;
    logic           advance;
    logic           pop_eff;
    logic           underrun_set;
    logic [17:0]    issue_addr;

    assign flush        = line_start | ~vdp_super;
    assign pop_eff      = word_pop & (count_reg != '0) & ~flush;
    assign underrun_set = word_pop & (count_reg == '0) & ~flush;
    assign rd_ptr_inc   = rd_ptr_reg + PW'(1);
    assign issue_addr   = line_start ? line_addr : next_addr_reg;

    // In IDLE nothing is in flight, so the slot reservation reduces to count < DEPTH.
    // A line_start in IDLE issues straight from the new line parameters.
    assign can_issue = vdp_super & super_res_drawing &
                       (line_start ? (line_words != '0)
                                   : ((words_left_reg != '0) && (count_reg < CW'(DEPTH))));

    always_comb begin
        state_next = state_reg;
        drop_next  = drop_reg;
        issue      = 1'b0;
        push       = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                drop_next = 1'b0;
                if (can_issue) begin
                    issue      = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    drop_next = 1'b0;
                    if (drop_reg || flush) begin
                        state_next = mem_rdata_valid ? ST_IDLE : ST_DRAIN;
                    end else begin
                        advance = 1'b1;
                        if (mem_rdata_valid) begin
                            push       = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_WAIT;
                        end
                    end
                end else if (flush) begin
                    // Request stays on the bus; its data belongs to the old line.
                    drop_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rdata_valid) begin
                    push       = ~flush;
                    state_next = ST_IDLE;
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rdata_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            drop_reg       <= 1'b0;
            mem_addr_reg   <= '0;
            next_addr_reg  <= '0;
            words_left_reg <= '0;
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            vrm_reg        <= '0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            drop_reg  <= drop_next;
            if (issue) begin
                mem_addr_reg <= issue_addr;
            end
            if (flush) begin
                next_addr_reg  <= line_addr;
                words_left_reg <= line_words;
                count_reg      <= '0;
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                underrun_reg   <= 1'b0;
            end else begin
                if (advance) begin
                    next_addr_reg  <= next_addr_reg + 18'd1;
                    words_left_reg <= words_left_reg - 9'd1;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop_eff) begin
                    rd_ptr_reg <= rd_ptr_inc;
                end
                case ({push, pop_eff})
                    2'b10:   count_reg <= count_reg + CW'(1);
                    2'b01:   count_reg <= count_reg - CW'(1);
                    default: count_reg <= count_reg;
                endcase
                // Head register: next stored word on pop, or the incoming word when it becomes head.
                if (pop_eff && (count_reg >= CW'(2))) begin
                    vrm_reg <= mem_reg[rd_ptr_inc];
                end else if (push && ((count_reg == '0) || pop_eff)) begin
                    vrm_reg <= mem_rdata;
                end
                if (underrun_set) begin
                    underrun_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= mem_rdata;
        end
    end

`ifdef VDP_SUPER_PREFETCH_STATS_EN
    logic [15:0] underrun_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count_reg <= '0;
        end else if (underrun_set && (underrun_count_reg != 16'hFFFF)) begin
            underrun_count_reg <= underrun_count_reg + 16'd1;
        end
    end

    assign underrun_count = underrun_count_reg;
`else
    assign underrun_count = '0;
`endif

    assign vrm_32     = vrm_reg;
    assign word_valid = (count_reg != '0);
    assign mem_rd_req = (state_reg == ST_REQ);
    assign mem_addr   = mem_addr_reg;
    assign underrun   = underrun_reg;

endmodule
